// File: rtl/matvec_sequencer_pkg.sv
// Shared definitions for the matrix-vector sequencer: FSM state encoding.
package matvec_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    WRITE     = 3'd4,
    FINISH    = 3'd5
  } state_t;

endpackage

// File: rtl/matvec_sequencer_row_addr_gen.sv
// Row bookkeeping: row index counter, row base accumulator and flat
// matrix-memory address translation.
module row_addr_gen #(
  parameter int unsigned matrix_width      = 128,
  parameter int unsigned matrix_height     = 128,
  parameter int unsigned address_width     = 8,
  parameter int unsigned mem_address_width = 16,
  parameter int unsigned res_address_width = 8
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         clear,
  input  logic                         advance,
  input  logic [address_width-1:0]     row_addr,
  output logic [mem_address_width-1:0] mem_addr_c,
  output logic [res_address_width-1:0] row_idx,
  output logic                         last_row_c
);

  localparam logic [mem_address_width-1:0] row_step = mem_address_width'(matrix_width);
  localparam logic [res_address_width-1:0] last_idx = res_address_width'(matrix_height - 1);

  logic [mem_address_width-1:0] row_base;

  // Base advances by one row width per row, so no multiplier is needed.
  always_ff @(posedge CLK) begin
    if (RST || clear) begin
      row_base <= '0;
      row_idx  <= '0;
    end else if (advance) begin
      row_base <= row_base + row_step;
      row_idx  <= row_idx + res_address_width'(1);
    end
  end

  assign mem_addr_c = row_base + mem_address_width'(row_addr);
  assign last_row_c = (row_idx == last_idx);

endmodule

// File: rtl/matvec_sequencer.sv
// Matrix-vector multiply sequencer: launches the row engine once per row and
// writes each returned dot product into the result memory at the row index.
module matvec_sequencer
  import matvec_sequencer_pkg::*;
#(
  parameter int unsigned matrix_width      = 128,
  parameter int unsigned matrix_height     = 128,
  parameter int unsigned data_width        = 32,
  parameter int unsigned address_width     = 8,
  parameter int unsigned mem_address_width = 16,
  parameter int unsigned res_address_width = 8
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         GO,
  output logic                         BUSY,
  output logic                         DONE,
  output logic                         ROW_ST,
  input  logic                         ROW_RD,
  input  logic [data_width-1:0]        ROW_DATA,
  input  logic [address_width-1:0]    ROW_ADDR,
  output logic [mem_address_width-1:0] MEM_ADDR,
  output logic                         RES_WR,
  output logic [res_address_width-1:0] RES_ADDR,
  output logic [data_width-1:0]        RES_DATA,
  output logic [res_address_width-1:0] ROW_IDX
);

  state_t state;
  state_t state_next;
  logic   clear;
  logic   advance;
  logic   capture;
  logic   last_row_c;
  logic [res_address_width-1:0] row_idx;

  row_addr_gen #(
    .matrix_width     (matrix_width),
    .matrix_height    (matrix_height),
    .address_width    (address_width),
    .mem_address_width(mem_address_width),
    .res_address_width(res_address_width)
  ) u_row_addr_gen (
    .CLK       (CLK),
    .RST       (RST),
    .clear     (clear),
    .advance   (advance),
    .row_addr  (ROW_ADDR),
    .mem_addr_c(MEM_ADDR),
    .row_idx   (row_idx),
    .last_row_c(last_row_c)
  );

  assign ROW_IDX = row_idx;

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  // Next state plus per-state control strobes to the row bookkeeping.
  always_comb begin
    state_next = state;
    clear      = 1'b0;
    advance    = 1'b0;
    capture    = 1'b0;
    unique case (state)
      IDLE: begin
        if (GO) begin
          clear      = 1'b1;
          state_next = START;
        end
      end
      START: state_next = WAIT_BUSY;
      // Engine RD idles high; wait for it to drop before waiting for completion.
      WAIT_BUSY: begin
        if (!ROW_RD) state_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (ROW_RD) begin
          capture    = 1'b1;
          state_next = WRITE;
        end
      end
      WRITE: begin
        if (last_row_c) begin
          state_next = FINISH;
        end else begin
          advance    = 1'b1;
          state_next = START;
        end
      end
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered from the next state so each is high exactly in its state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      ROW_ST   <= 1'b0;
      RES_WR   <= 1'b0;
      RES_ADDR <= '0;
      RES_DATA <= '0;
    end else begin
      BUSY   <= (state_next != IDLE);
      DONE   <= (state_next == FINISH);
      ROW_ST <= (state_next == START);
      RES_WR <= (state_next == WRITE);
      if (capture) begin
        RES_DATA <= ROW_DATA;
        RES_ADDR <= row_idx;
      end
    end
  end

endmodule

// File: tb/tb_matvec_sequencer.sv
// Scoreboard bench for matvec_sequencer: three instances (single row, three
// rows, narrow address wrap) each driven by a behavioural row engine.
module tb_matvec_sequencer;

  typedef struct packed {
    logic        kind;   // 0: result write, 1: DONE
    logic [1:0]  inst;
    logic [7:0]  addr;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic [2:0]  rst = 3'b111;
  logic [2:0]  go  = 3'b000;
  logic [2:0]  busy, done, row_st, res_wr, rd;
  logic [7:0]  row_addr [3];
  logic [7:0]  res_addr [3];
  logic [7:0]  row_idx  [3];
  logic [31:0] row_data [3];
  logic [31:0] res_data [3];
  logic [15:0] mem_addr [3];

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   st_cnt [3];
  logic [2:0] prev_wr   = 3'b000;
  logic [2:0] prev_done = 3'b000;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned H  = (g == 0) ? 1 : 3;
    localparam int unsigned W  = (g == 2) ? 6 : 4;
    localparam int unsigned MW = (g == 2) ? 4 : 16;

    logic [MW-1:0] dut_mem_addr;
    logic          eng_rd;
    logic [31:0]   eng_data;
    logic [3:0]    eng_cnt;

    matvec_sequencer #(
      .matrix_width     (W),
      .matrix_height    (H),
      .data_width       (32),
      .address_width    (8),
      .mem_address_width(MW),
      .res_address_width(8)
    ) u_dut (
      .CLK     (clk),
      .RST     (rst[g]),
      .GO      (go[g]),
      .BUSY    (busy[g]),
      .DONE    (done[g]),
      .ROW_ST  (row_st[g]),
      .ROW_RD  (eng_rd),
      .ROW_DATA(eng_data),
      .ROW_ADDR(row_addr[g]),
      .MEM_ADDR(dut_mem_addr),
      .RES_WR  (res_wr[g]),
      .RES_ADDR(res_addr[g]),
      .RES_DATA(res_data[g]),
      .ROW_IDX (row_idx[g])
    );

    // Behavioural engine: RD drops after a start, rises 6 cycles later with the result.
    always_ff @(posedge clk) begin
      if (rst[g]) begin
        eng_rd   <= 1'b1;
        eng_cnt  <= 4'd0;
        eng_data <= 32'd0;
      end else if (row_st[g]) begin
        eng_rd  <= 1'b0;
        eng_cnt <= 4'd6;
      end else if (!eng_rd) begin
        if (eng_cnt == 4'd1) begin
          eng_rd   <= 1'b1;
          eng_data <= result_of(g, row_idx[g]);
        end
        eng_cnt <= eng_cnt - 4'd1;
      end
    end

    assign rd[g]       = eng_rd;
    assign row_data[g] = eng_data;
    assign mem_addr[g] = 16'(dut_mem_addr);
  end

  function automatic logic [31:0] result_of(input int g, input logic [7:0] idx);
    case (g)
      0:       return 32'h2A;
      1:       return (32'(idx) + 32'd1) * 32'd10;
      default: return 32'd100 + 32'(idx);
    endcase
  endfunction

  // Monitor: pops and compares whenever a write or DONE appears.
  always @(negedge clk) begin
    exp_t e;
    for (int g = 0; g < 3; g++) begin
      if (res_wr[g] === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write inst=%0d addr=%0d data=%0d (none expected)", g, res_addr[g], res_data[g]);
        end else begin
          e = exp_q.pop_front();
          if (e.kind != 1'b0 || 32'(e.inst) != g || e.addr != res_addr[g] || e.data != res_data[g]) begin
            errors++;
            $display("FAIL result_write got inst=%0d addr=%0d data=%0d expected kind=%0d inst=%0d addr=%0d data=%0d",
                     g, res_addr[g], res_data[g], e.kind, e.inst, e.addr, e.data);
          end
        end
      end
      if (done[g] === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done inst=%0d (none expected)", g);
        end else begin
          e = exp_q.pop_front();
          if (e.kind != 1'b1 || 32'(e.inst) != g) begin
            errors++;
            $display("FAIL done_order got DONE inst=%0d expected kind=%0d inst=%0d", g, e.kind, e.inst);
          end
        end
        checks++;
        if (prev_wr[g] !== 1'b1) begin
          errors++;
          $display("FAIL done_after_write inst=%0d prev RES_WR=%b expected 1", g, prev_wr[g]);
        end
      end
      if (prev_done[g] === 1'b1) begin
        checks++;
        if (busy[g] !== 1'b0) begin
          errors++;
          $display("FAIL busy_after_done inst=%0d BUSY=%b expected 0", g, busy[g]);
        end
      end
      if (row_st[g] === 1'b1) st_cnt[g]++;
      prev_wr[g]   = res_wr[g];
      prev_done[g] = done[g];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic push_wr(input int g, input int addr, input int data);
    exp_q.push_back('{kind: 1'b0, inst: 2'(g), addr: 8'(addr), data: 32'(data)});
  endtask

  task automatic push_done(input int g);
    exp_q.push_back('{kind: 1'b1, inst: 2'(g), addr: 8'd0, data: 32'd0});
  endtask

  task automatic pulse_go(input int g);
    @(posedge clk); #1 go[g] = 1'b1;
    @(posedge clk); #1 go[g] = 1'b0;
  endtask

  task automatic wait_done(input int g, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done[g] === 1'b1) return;
    end
    checks++; errors++;
    $display("FAIL wait_done_timeout inst=%0d after %0d cycles", g, budget);
  endtask

  task automatic wait_row(input int g, input int idx, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (32'(row_idx[g]) == idx) return;
    end
    checks++; errors++;
    $display("FAIL wait_row_timeout inst=%0d row=%0d after %0d cycles", g, idx, budget);
  endtask

  initial begin
    for (int g = 0; g < 3; g++) begin
      row_addr[g] = 8'd0;
      st_cnt[g]   = 0;
    end

    // Reset and idle
    repeat (2) @(posedge clk);
    #1 rst = 3'b000;
    for (int g = 0; g < 3; g++) row_addr[g] = 8'd5;
    @(negedge clk);
    chk("rst_busy",     32'(busy),        0);
    chk("rst_done",     32'(done),        0);
    chk("rst_row_st",   32'(row_st),      0);
    chk("rst_res_wr",   32'(res_wr),      0);
    chk("rst_res_addr", 32'(res_addr[1]), 0);
    chk("rst_res_data", res_data[1],      0);
    chk("rst_row_idx",  32'(row_idx[1]),  0);
    chk("rst_mem_addr", 32'(mem_addr[1]), 5);
    chk("rst_mem_addr_narrow", 32'(mem_addr[2]), 5);
    for (int g = 0; g < 3; g++) begin
      row_addr[g] = 8'd0;
      st_cnt[g]   = 0;
    end

    // Single-row run
    push_wr(0, 0, 32'h2A);
    push_done(0);
    pulse_go(0);
    wait_done(0, 100);
    repeat (3) @(negedge clk);
    chk("single_row_st_count", 32'(st_cnt[0]), 1);

    // Three-row run with address check in row 2
    st_cnt[1] = 0;
    push_wr(1, 0, 10); push_wr(1, 1, 20); push_wr(1, 2, 30); push_done(1);
    pulse_go(1);
    wait_row(1, 2, 100);
    row_addr[1] = 8'd3;
    #1 chk("row2_mem_addr", 32'(mem_addr[1]), 11);
    wait_done(1, 100);
    repeat (3) @(negedge clk);
    chk("three_row_st_count", 32'(st_cnt[1]), 3);

    // Address wrap in a 4-bit memory space
    push_wr(2, 0, 100); push_wr(2, 1, 101); push_wr(2, 2, 102); push_done(2);
    pulse_go(2);
    wait_row(2, 2, 100);
    row_addr[2] = 8'd5;
    #1 chk("wrap_mem_addr", 32'(mem_addr[2]), 1);
    wait_done(2, 100);
    repeat (3) @(negedge clk);

    // GO pulses mid-run are ignored
    st_cnt[1] = 0;
    push_wr(1, 0, 10); push_wr(1, 1, 20); push_wr(1, 2, 30); push_done(1);
    pulse_go(1);
    repeat (4) @(posedge clk);
    pulse_go(1);
    repeat (7) @(posedge clk);
    pulse_go(1);
    wait_done(1, 100);
    repeat (8) @(negedge clk);
    chk("go_busy_st_count", 32'(st_cnt[1]), 3);
    chk("go_busy_idle",     32'(busy[1]),   0);

    // Reset in WAIT_DONE of row 1
    st_cnt[1] = 0;
    push_wr(1, 0, 10);
    pulse_go(1);
    wait_row(1, 1, 100);
    repeat (2) @(posedge clk);
    #1 rst[1] = 1'b1;
    @(posedge clk);
    #1 rst[1] = 1'b0;
    @(negedge clk);
    chk("midrst_busy",    32'(busy[1]),    0);
    chk("midrst_row_idx", 32'(row_idx[1]), 0);
    repeat (12) @(negedge clk);
    chk("midrst_st_count", 32'(st_cnt[1]), 2);
    chk("midrst_pending",  32'(exp_q.size()), 0);
    push_wr(1, 0, 10); push_wr(1, 1, 20); push_wr(1, 2, 30); push_done(1);
    pulse_go(1);
    wait_done(1, 100);
    repeat (3) @(negedge clk);

    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
